// File: rtl/nbit_mux_defs.sv
// Shared slot-state encoding for the 1:2 demux output slots.
package nbit_mux_defs;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/nbit_one_two_demux_if.sv
// Input stream plus the two output streams and their handshake counters.
interface nbit_one_two_demux_if #(
  parameter int IN_WIDTH  = 8,
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int CNT_WIDTH = 8
);
  logic [IN_WIDTH-1:0]  bus_in;
  logic                 select;
  logic                 in_valid;
  logic                 in_ready;
  logic [A_WIDTH-1:0]   bus_a;
  logic                 a_valid;
  logic                 a_ready;
  logic [B_WIDTH-1:0]   bus_b;
  logic                 b_valid;
  logic                 b_ready;
  logic [CNT_WIDTH-1:0] a_count;
  logic [CNT_WIDTH-1:0] b_count;

  modport master (
    output bus_in, select, in_valid, a_ready, b_ready,
    input  in_ready, bus_a, a_valid, bus_b, b_valid, a_count, b_count
  );

  modport slave (
    input  bus_in, select, in_valid, a_ready, b_ready,
    output in_ready, bus_a, a_valid, bus_b, b_valid, a_count, b_count
  );
endinterface

// File: rtl/nbit_one_two_demux_out_slot.sv
// One-entry output slot: width-adapts the input word, holds it until drained,
// and counts completed output handshakes.
module nbit_out_slot
  import nbit_mux_defs::*;
#(
  parameter int IN_W      = 8,
  parameter int W         = 8,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IN_W-1:0]      din,
  input  logic                 fill,
  input  logic                 ready,
  output logic                 valid,
  output logic [W-1:0]         data,
  output logic                 can_accept,
  output logic [CNT_WIDTH-1:0] count
);

  slot_state_t state, state_n;
  logic [W-1:0] din_w;
  logic         drain;

  generate
    if (IN_W >= W) begin : g_trunc
      assign din_w = din[W-1:0];
    end else begin : g_zext
      assign din_w = {{(W-IN_W){1'b0}}, din};
    end
  endgenerate

  assign valid      = (state == FULL);
  assign drain      = valid & ready;
  // A full slot can take a new word in the same cycle it is drained.
  assign can_accept = (state == EMPTY) | ready;

  always_comb begin
    state_n = state;
    case (state)
      EMPTY:   if (fill) state_n = FULL;
      FULL:    if (drain && !fill) state_n = EMPTY;
      default: state_n = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      data  <= '0;
      count <= '0;
    end else begin
      state <= state_n;
      if (fill)  data  <= din_w;
      if (drain) count <= count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/nbit_one_two_demux.sv
// 1:2 stream demux; select steers each accepted word into slot A or slot B.
module nbit_one_two_demux
  import nbit_mux_defs::*;
#(
  parameter int IN_WIDTH  = 8,
  parameter int A_WIDTH   = 8,
  parameter int B_WIDTH   = 8,
  parameter int CNT_WIDTH = 8
) (
  input logic                clk,
  input logic                reset,
  nbit_one_two_demux_if.slave bus
);

  logic a_acc, b_acc;
  logic a_fill, b_fill;

  // Only the addressed slot gates in_ready, so words never pass a blocked port.
  assign bus.in_ready = bus.select ? b_acc : a_acc;
  assign a_fill       = bus.in_valid & ~bus.select & a_acc;
  assign b_fill       = bus.in_valid &  bus.select & b_acc;

  nbit_out_slot #(
    .IN_W(IN_WIDTH), .W(A_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_slot_a (
    .clk        (clk),
    .reset      (reset),
    .din        (bus.bus_in),
    .fill       (a_fill),
    .ready      (bus.a_ready),
    .valid      (bus.a_valid),
    .data       (bus.bus_a),
    .can_accept (a_acc),
    .count      (bus.a_count)
  );

  nbit_out_slot #(
    .IN_W(IN_WIDTH), .W(B_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_slot_b (
    .clk        (clk),
    .reset      (reset),
    .din        (bus.bus_in),
    .fill       (b_fill),
    .ready      (bus.b_ready),
    .valid      (bus.b_valid),
    .data       (bus.bus_b),
    .can_accept (b_acc),
    .count      (bus.b_count)
  );

endmodule

// File: tb/tb_nbit_one_two_demux.sv
// Directed bench: table of per-cycle vectors on an 8/8/8/8 instance, plus a
// hand sequence on a 8/4/12/2 instance for width adaptation and counter wrap.
module tb_nbit_one_two_demux;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  nbit_one_two_demux_if #(.IN_WIDTH(8), .A_WIDTH(8), .B_WIDTH(8),  .CNT_WIDTH(8)) if0 ();
  nbit_one_two_demux_if #(.IN_WIDTH(8), .A_WIDTH(4), .B_WIDTH(12), .CNT_WIDTH(2)) if1 ();

  nbit_one_two_demux #(.IN_WIDTH(8), .A_WIDTH(8), .B_WIDTH(8), .CNT_WIDTH(8)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave)
  );
  nbit_one_two_demux #(.IN_WIDTH(8), .A_WIDTH(4), .B_WIDTH(12), .CNT_WIDTH(2)) dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave)
  );

  typedef struct {
    logic       rst, iv, sel;
    logic [7:0] din;
    logic       ar, br;
    logic       rdy;
    logic       av;
    logic [7:0] a;
    logic       bv;
    logic [7:0] b;
    logic [7:0] ac, bc;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //          rst iv sel din    ar br rdy av a      bv b      ac    bc
    vt[0]  = '{1'b0,1'b1,1'b0,8'hA5,1'b1,1'b0,1'b1,1'b1,8'hA5,1'b0,8'h00,8'd0,8'd0};
    vt[1]  = '{1'b0,1'b0,1'b0,8'h00,1'b1,1'b0,1'b1,1'b0,8'hA5,1'b0,8'h00,8'd1,8'd0};
    vt[2]  = '{1'b0,1'b1,1'b0,8'h11,1'b0,1'b0,1'b1,1'b1,8'h11,1'b0,8'h00,8'd1,8'd0};
    vt[3]  = '{1'b0,1'b1,1'b0,8'h22,1'b0,1'b0,1'b0,1'b1,8'h11,1'b0,8'h00,8'd1,8'd0};
    vt[4]  = '{1'b0,1'b1,1'b0,8'h22,1'b1,1'b0,1'b1,1'b1,8'h22,1'b0,8'h00,8'd2,8'd0};
    vt[5]  = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b0,1'b1,8'h22,1'b0,8'h00,8'd2,8'd0};
    vt[6]  = '{1'b0,1'b1,1'b1,8'h33,1'b0,1'b0,1'b1,1'b1,8'h22,1'b1,8'h33,8'd2,8'd0};
    vt[7]  = '{1'b0,1'b1,1'b0,8'h44,1'b0,1'b0,1'b0,1'b1,8'h22,1'b1,8'h33,8'd2,8'd0};
    vt[8]  = '{1'b0,1'b1,1'b1,8'h55,1'b0,1'b0,1'b0,1'b1,8'h22,1'b1,8'h33,8'd2,8'd0};
    vt[9]  = '{1'b0,1'b0,1'b1,8'h00,1'b0,1'b1,1'b1,1'b1,8'h22,1'b0,8'h33,8'd2,8'd1};
    vt[10] = '{1'b0,1'b1,1'b1,8'h66,1'b0,1'b0,1'b1,1'b1,8'h22,1'b1,8'h66,8'd2,8'd1};
    vt[11] = '{1'b1,1'b1,1'b0,8'h77,1'b1,1'b1,1'b1,1'b0,8'h00,1'b0,8'h00,8'd0,8'd0};
    vt[12] = '{1'b0,1'b0,1'b0,8'h00,1'b0,1'b0,1'b1,1'b0,8'h00,1'b0,8'h00,8'd0,8'd0};
    vt[13] = '{1'b0,1'b1,1'b1,8'h81,1'b0,1'b1,1'b1,1'b0,8'h00,1'b1,8'h81,8'd0,8'd0};
    vt[14] = '{1'b0,1'b1,1'b1,8'h82,1'b0,1'b1,1'b1,1'b0,8'h00,1'b1,8'h82,8'd0,8'd1};
    vt[15] = '{1'b0,1'b1,1'b1,8'h83,1'b0,1'b1,1'b1,1'b0,8'h00,1'b1,8'h83,8'd0,8'd2};
    vt[16] = '{1'b0,1'b0,1'b1,8'h00,1'b0,1'b1,1'b1,1'b0,8'h00,1'b0,8'h83,8'd0,8'd3};

    reset = 1'b1;
    if0.in_valid = 1'b0; if0.select = 1'b0; if0.bus_in = '0; if0.a_ready = 1'b0; if0.b_ready = 1'b0;
    if1.in_valid = 1'b0; if1.select = 1'b0; if1.bus_in = '0; if1.a_ready = 1'b0; if1.b_ready = 1'b0;
    repeat (2) step();

    chk("rst0_a_valid", 32'(if0.a_valid), 32'h0);
    chk("rst0_b_valid", 32'(if0.b_valid), 32'h0);
    chk("rst0_bus_a",   32'(if0.bus_a),   32'h0);
    chk("rst0_bus_b",   32'(if0.bus_b),   32'h0);
    chk("rst0_a_count", 32'(if0.a_count), 32'h0);
    chk("rst0_b_count", 32'(if0.b_count), 32'h0);
    chk("rst1_a_valid", 32'(if1.a_valid), 32'h0);
    chk("rst1_b_valid", 32'(if1.b_valid), 32'h0);
    chk("rst1_bus_a",   32'(if1.bus_a),   32'h0);
    chk("rst1_bus_b",   32'(if1.bus_b),   32'h0);
    chk("rst1_b_count", 32'(if1.b_count), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      reset        = vt[i].rst;
      if0.in_valid = vt[i].iv;
      if0.select   = vt[i].sel;
      if0.bus_in   = vt[i].din;
      if0.a_ready  = vt[i].ar;
      if0.b_ready  = vt[i].br;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(if0.in_ready), 32'(vt[i].rdy));
      step();
      chk($sformatf("v%0d_a_valid", i), 32'(if0.a_valid), 32'(vt[i].av));
      chk($sformatf("v%0d_bus_a",   i), 32'(if0.bus_a),   32'(vt[i].a));
      chk($sformatf("v%0d_b_valid", i), 32'(if0.b_valid), 32'(vt[i].bv));
      chk($sformatf("v%0d_bus_b",   i), 32'(if0.bus_b),   32'(vt[i].b));
      chk($sformatf("v%0d_a_count", i), 32'(if0.a_count), 32'(vt[i].ac));
      chk($sformatf("v%0d_b_count", i), 32'(if0.b_count), 32'(vt[i].bc));
    end
    reset = 1'b0;
    if0.in_valid = 1'b0;

    // Narrow A truncates, wide B zero-extends.
    if1.in_valid = 1'b1; if1.select = 1'b0; if1.bus_in = 8'hC7;
    step();
    if1.select = 1'b1;
    step();
    chk("w_a_valid", 32'(if1.a_valid), 32'h1);
    chk("w_bus_a",   32'(if1.bus_a),   32'h7);
    chk("w_b_valid", 32'(if1.b_valid), 32'h1);
    chk("w_bus_b",   32'(if1.bus_b),   32'h0C7);

    // Five B handshakes with a 2-bit counter: 1,2,3,0,1.
    if1.b_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) if1.in_valid = 1'b0;
      step();
      chk($sformatf("wrap%0d_b_count", k), 32'(if1.b_count), 32'((k + 1) % 4));
    end
    chk("wrap_b_valid", 32'(if1.b_valid), 32'h0);
    chk("wrap_a_count", 32'(if1.a_count), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
